ring_seek_controller: RTL

RING_SEEK_CONTROLLER -- requirements
Module: ring_seek_controller

---
 rtl/ring_seek_controller.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/ring_seek_controller.sv
// Ring position seek controller: two-requester round-robin front end driving a
// single-step ring mover with shortest-direction selection and post-step settling.
module ring_seek_controller #(
  parameter int NPOS   = 10,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req0_valid,
  input  logic            req1_valid,
  input  logic [3:0]      req0_target,
  input  logic [3:0]      req1_target,
  output logic            req0_ready,
  output logic            req1_ready,
  output logic [NPOS-1:0] pos_onehot,
  output logic [3:0]      pos,
  output logic            step,
  output logic            dir,
  output logic            busy,
  output logic            done,
  output logic            done_id,
  output logic            done_err
);

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_WAIT, S_DONE} state_t;

  localparam logic [3:0] LAST      = 4'(NPOS - 1);
  localparam logic [4:0] NPOS5     = 5'(NPOS);
  localparam logic [4:0] HALF5     = 5'(NPOS / 2);
  localparam logic [3:0] SETTLE_M1 = 4'((SETTLE > 0) ? SETTLE - 1 : 0);

  state_t            state_q, state_d;
  logic [3:0]        pos_q, pos_d;
  logic [NPOS-1:0]   oh_q, oh_d;
  logic [3:0]        tgt_q, tgt_d;
  logic              id_q, id_d;
  logic              err_q, err_d;
  logic              ptr_q, ptr_d;
  logic [3:0]        wcnt_q, wcnt_d;

  logic              gnt0, gnt1, step_c, dir_c, done_c;
  logic [3:0]        sel_tgt;
  logic [4:0]        diff;
  logic              dir_up;

  // Forward distance around the ring; ties at exactly half favour the up direction.
  assign diff   = ({1'b0, tgt_q} >= {1'b0, pos_q}) ? ({1'b0, tgt_q} - {1'b0, pos_q})
                                                   : ({1'b0, tgt_q} + NPOS5 - {1'b0, pos_q});
  assign dir_up = (diff <= HALF5);

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    oh_d    = oh_q;
    tgt_d   = tgt_q;
    id_d    = id_q;
    err_d   = err_q;
    ptr_d   = ptr_q;
    wcnt_d  = wcnt_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    step_c  = 1'b0;
    dir_c   = 1'b0;
    done_c  = 1'b0;
    sel_tgt = req0_target;
    case (state_q)
      S_IDLE: begin
        if (req0_valid && (!req1_valid || !ptr_q)) gnt0 = 1'b1;
        else if (req1_valid)                        gnt1 = 1'b1;
        if (gnt0 || gnt1) begin
          sel_tgt = gnt1 ? req1_target : req0_target;
          tgt_d   = sel_tgt;
          id_d    = gnt1;
          err_d   = ({1'b0, sel_tgt} >= NPOS5);
          state_d = (err_d || (sel_tgt == pos_q)) ? S_DONE : S_MOVE;
        end
      end
      S_MOVE: begin
        step_c = 1'b1;
        dir_c  = dir_up;
        if (dir_up) begin
          pos_d = (pos_q == LAST) ? 4'd0 : pos_q + 4'd1;
          oh_d  = {oh_q[NPOS-2:0], oh_q[NPOS-1]};
        end else begin
          pos_d = (pos_q == 4'd0) ? LAST : pos_q - 4'd1;
          oh_d  = {oh_q[0], oh_q[NPOS-1:1]};
        end
        if (SETTLE > 0) begin
          state_d = S_WAIT;
          wcnt_d  = SETTLE_M1;
        end else begin
          state_d = (pos_d == tgt_q) ? S_DONE : S_MOVE;
        end
      end
      S_WAIT: begin
        if (wcnt_q == 4'd0) state_d = (pos_q == tgt_q) ? S_DONE : S_MOVE;
        else                wcnt_d  = wcnt_q - 4'd1;
      end
      S_DONE: begin
        done_c  = 1'b1;
        ptr_d   = ~id_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pos_q   <= 4'd0;
      oh_q    <= {{(NPOS-1){1'b0}}, 1'b1};
      ptr_q   <= 1'b0;
      wcnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      oh_q    <= oh_d;
      ptr_q   <= ptr_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_ff @(posedge clk) begin
    tgt_q <= tgt_d;
    id_q  <= id_d;
    err_q <= err_d;
  end

  // Outputs are forced quiet while reset is held so an aborted seek never pulses.
  assign req0_ready = gnt0 & ~reset;
  assign req1_ready = gnt1 & ~reset;
  assign step       = step_c & ~reset;
  assign dir        = dir_c & ~reset;
  assign busy       = (state_q != S_IDLE) & ~reset;
  assign done       = done_c & ~reset;
  assign done_id    = done_c & id_q & ~reset;
  assign done_err   = done_c & err_q & ~reset;
  assign pos        = pos_q;
  assign pos_onehot = oh_q;

endmodule
